// File: rtl/tdd_frame_sequencer.sv
// TDD frame scheduler: runs a frame counter for a finite or infinite burst and
// drives per-channel on/off windows (VCO, RF, datapath enables) from counter offsets.
module tdd_frame_sequencer #(
    parameter int                     CHANNEL_COUNT     = 4,
    parameter int                     REGISTER_WIDTH    = 32,
    parameter int                     BURST_COUNT_WIDTH = 16,
    parameter logic [CHANNEL_COUNT-1:0] CHANNEL_POLARITY  = {CHANNEL_COUNT{1'b0}}
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    enable,
    input  logic                                    sync_external,
    input  logic                                    sync_in,
    input  logic [REGISTER_WIDTH-1:0]               frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0]            burst_count,
    input  logic [REGISTER_WIDTH-1:0]               counter_init,
    input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] ch_on,
    input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] ch_off,
    output logic [REGISTER_WIDTH-1:0]               counter,
    output logic [CHANNEL_COUNT-1:0]                ch_out,
    output logic                                    frame_start,
    output logic                                    done,
    output logic [1:0]                              state,
    output logic                                    config_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                       state_q,      state_d;
    logic [REGISTER_WIDTH-1:0]    counter_q,    counter_d;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_q,  frame_cnt_d;
    logic [BURST_COUNT_WIDTH-1:0] burst_q,      burst_d;
    logic [REGISTER_WIDTH-1:0]    init_q,       init_d;
    logic [CHANNEL_COUNT-1:0]     active_q,     active_d;
    logic                         done_q,       done_d;
    logic                         config_err_q, config_err_d;

    logic [REGISTER_WIDTH-1:0]    frame_last;
    logic [BURST_COUNT_WIDTH-1:0] frame_inc;
    logic                         wrap;
    logic                         length_zero;

    // >= rather than == so a counter_init past the frame end still wraps on the first step.
    assign frame_last  = frame_length - REGISTER_WIDTH'(1);
    assign wrap        = (counter_q >= frame_last);
    assign frame_inc   = frame_cnt_q + BURST_COUNT_WIDTH'(1);
    assign length_zero = (frame_length == '0);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        frame_cnt_d  = frame_cnt_q;
        burst_d      = burst_q;
        init_d       = init_q;
        done_d       = 1'b0;
        config_err_d = enable && length_zero;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (enable && !length_zero) begin
                    burst_d     = burst_count;
                    init_d      = counter_init;
                    frame_cnt_d = '0;
                    if (sync_external) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d   = ST_RUNNING;
                        counter_d = counter_init;
                    end
                end
            end
            ST_ARMED: begin
                counter_d = '0;
                if (sync_in) begin
                    state_d   = ST_RUNNING;
                    counter_d = init_q;
                end
            end
            ST_RUNNING: begin
                // A resync realigns the frame and takes precedence over a wrap.
                if (sync_external && sync_in) begin
                    counter_d = init_q;
                end else if (wrap) begin
                    counter_d   = '0;
                    frame_cnt_d = frame_inc;
                    if ((burst_q != '0) && (frame_inc == burst_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    counter_d = counter_q + REGISTER_WIDTH'(1);
                end
            end
            ST_DONE: begin
                counter_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase

        if (!enable) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            done_d    = 1'b0;
        end
    end

    // Set/clear window per channel; clear wins when both offsets match the same count.
    always_comb begin
        active_d = active_q;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (counter_q == ch_off[i*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                active_d[i] = 1'b0;
            end else if (counter_q == ch_on[i*REGISTER_WIDTH +: REGISTER_WIDTH]) begin
                active_d[i] = 1'b1;
            end
        end
        if ((state_q != ST_RUNNING) || (state_d != ST_RUNNING)) begin
            active_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            frame_cnt_q  <= '0;
            burst_q      <= '0;
            init_q       <= '0;
            active_q     <= '0;
            done_q       <= 1'b0;
            config_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            frame_cnt_q  <= frame_cnt_d;
            burst_q      <= burst_d;
            init_q       <= init_d;
            active_q     <= active_d;
            done_q       <= done_d;
            config_err_q <= config_err_d;
        end
    end

    assign counter     = counter_q;
    assign ch_out      = active_q ^ CHANNEL_POLARITY;
    assign frame_start = (state_q == ST_RUNNING) && (counter_q == '0);
    assign done        = done_q;
    assign state       = state_q;
    assign config_err  = config_err_q;

endmodule

// File: doc/tdd_frame_sequencer.md
Name: tdd_frame_sequencer

Overview:
- Cycle-accurate TDD frame scheduler; sits between the TDD register map and the RF/DMA gating outputs.
- Runs a frame counter, started either by enable or by an external sync pulse, for a finite or infinite burst of frames.
- Drives CHANNEL_COUNT on/off windows, such as VCO, RF and datapath enables, from per-channel on/off counter offsets.

Parameters:
- CHANNEL_COUNT, 4, number of independent on/off output channels.
- REGISTER_WIDTH, 32, width of frame_length, counter_init, counter and each on/off offset.
- BURST_COUNT_WIDTH, 16, width of burst_count and the internal frame counter.
- CHANNEL_POLARITY, {CHANNEL_COUNT{1'b0}}, per-channel idle level; ch_out = window_active ^ CHANNEL_POLARITY.

Ports:
- clk  in  1  single clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  level; 1 = run, 0 = abort and return to IDLE.
- sync_external  in  1  1 = wait for sync_in before running; 0 = start on enable.
- sync_in  in  1  single-cycle sync pulse, already in the clk domain.
- frame_length  in  REGISTER_WIDTH  frame period in cycles; counter runs 0..frame_length-1.
- burst_count  in  BURST_COUNT_WIDTH  number of frames to run; 0 = infinite.
- counter_init  in  REGISTER_WIDTH  counter value on the first run cycle.
- ch_on  in  CHANNEL_COUNT*REGISTER_WIDTH  per-channel set offset; channel i uses slice i.
- ch_off  in  CHANNEL_COUNT*REGISTER_WIDTH  per-channel clear offset.
- counter  out  REGISTER_WIDTH  current frame counter, registered.
- ch_out  out  CHANNEL_COUNT  channel outputs, registered.
- frame_start  out  1  high on every RUNNING cycle with counter==0.
- done  out  1  one-cycle pulse on entry to DONE.
- state  out  2  IDLE=0, ARMED=1, RUNNING=2, DONE=3.
- config_err  out  1  high while enable=1 and frame_length==0.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, counter=0, frame count=0.
  - ch_out=CHANNEL_POLARITY, frame_start=0, done=0, config_err=0.
  - Reset has priority over all other events, including mid-run.
- IDLE:
  - counter held at 0.
  - If enable=1 and frame_length!=0: latch burst_count and counter_init, clear the frame count.
  - Next state is ARMED if sync_external=1, else RUNNING with counter=counter_init.
  - If enable=1 and frame_length==0: stay in IDLE with config_err=1.
- ARMED:
  - counter held at 0.
  - sync_in=1 -> RUNNING next cycle with counter=counter_init.
- RUNNING:
  - If counter >= frame_length-1 (unsigned; >= so that counter_init beyond the frame still wraps): counter<=0 and frame count increments. Otherwise counter<=counter+1.
  - On a wrap, if latched burst_count!=0 and the incremented frame count == burst_count: go to DONE. counter<=0 and done=1 for that one cycle.
  - sync_in=1 while sync_external=1 (resync): counter<=counter_init; frame count unchanged; resync wins over a simultaneous wrap.
  - frame_length, ch_on and ch_off are sampled live every cycle. burst_count and counter_init are used only as latched at start.
- DONE:
  - counter=0, channels inactive.
  - Hold until enable=0, then IDLE.
- enable=0 in any state: IDLE next cycle, counter=0, channels inactive. It wins over sync, wrap and DONE.
- Channel window, per channel, as a set/clear flop:
  - Evaluated only in RUNNING, against the registered counter value.
  - counter==ch_on sets active; counter==ch_off clears active; if both match, clear wins.
  - Windows with ch_on > ch_off span the frame boundary naturally.
  - active is cleared on any exit from RUNNING and is 0 in IDLE, ARMED and DONE.
  - Latency: ch_out changes the cycle after the counter shows the matching value.
- Widths: counter arithmetic is REGISTER_WIDTH unsigned, with no overflow beyond the wrap. With burst_count=0 the frame count wraps silently at 2^BURST_COUNT_WIDTH.

Test Plan:
- Basic burst:
  - Stimulus: sync_external=0, frame_length=10, burst_count=2, counter_init=0, ch0 on=2 off=5; assert enable.
  - Response: counter 0..9 twice; frame_start 2 pulses; ch_out[0] high while counter shows 3,4,5 in each frame; done pulses 20 cycles after entering RUNNING; state=DONE.
- External sync:
  - Stimulus: sync_external=1, counter_init=3; enable, then sync_in pulse 50 cycles later.
  - Response: state=ARMED for those 50 cycles with counter=0; next cycle state=RUNNING with counter=3.
- Cross-frame window:
  - Stimulus: frame_length=10, ch1 on=8 off=2, burst_count=0.
  - Response: ch_out[1] high while counter shows 9,0,1,2 every frame after the first on; runs indefinitely, done never asserts.
- Abort and resync:
  - Stimulus: enable drops at counter=6; then restart and pulse sync_in at counter=4.
  - Response: on the drop, IDLE next cycle, counter=0, ch_out=CHANNEL_POLARITY. On the resync, counter=counter_init next cycle and the frame count is unchanged.
- Boundaries:
  - Stimulus: frame_length=0 with enable=1; then counter_init=15 with frame_length=10; then on==off=4.
  - Response: frame_length=0 gives config_err=1 and state stays IDLE. counter_init=15 gives counter 15 -> 0 on the first step. on==off gives ch_out never active.
- Reset mid-run:
  - Stimulus: resetn=0 for 1 cycle while RUNNING with ch_out active.
  - Response: all outputs at reset values on the next edge; no done pulse.
